// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - register-file read, operand select and one-entry output register toward the ALU
module operand_fetch_stage #(
  parameter bit IMM_SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [15:0] imm,
  input  logic        use_imm,
  input  logic [2:0]  alu_op_in,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [2:0]  alu_op
);

  // Register file storage; entry 0 is never written so it stays at its reset value of 0.
  logic [31:0] r_regs [0:31];

  // Output stage registers.
  logic        r_out_valid;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [2:0]  r_alu_op;

  logic        w_wr_fire;
  logic [31:0] w_rs_data;
  logic [31:0] w_rt_data;
  logic [31:0] w_imm_ext;
  logic [31:0] w_b_sel;
  logic        w_in_ready;
  logic        w_accept;

  assign w_wr_fire = wr_en && (wr_addr != 5'd0);

  // Operand a read with write-through bypass; address 0 always reads 0.
  always_comb begin
    w_rs_data = 32'd0;
    if (rs_addr == 5'd0) begin
      w_rs_data = 32'd0;
    end else if (w_wr_fire && (wr_addr == rs_addr)) begin
      w_rs_data = wr_data;
    end else begin
      w_rs_data = r_regs[rs_addr];
    end
  end

  // Operand b register read with the same bypass rule as operand a.
  always_comb begin
    w_rt_data = 32'd0;
    if (rt_addr == 5'd0) begin
      w_rt_data = 32'd0;
    end else if (w_wr_fire && (wr_addr == rt_addr)) begin
      w_rt_data = wr_data;
    end else begin
      w_rt_data = r_regs[rt_addr];
    end
  end

  // Immediate extension chosen at elaboration, then the b source select.
  always_comb begin
    w_imm_ext = {16'd0, imm};
    if (IMM_SIGNED) begin
      w_imm_ext = {{16{imm[15]}}, imm};
    end
    w_b_sel = use_imm ? w_imm_ext : w_rt_data;
  end

  // The stage can take a new instruction when the output slot is free or draining, and never during flush.
  assign w_in_ready = (!r_out_valid || out_ready) && !flush;
  assign w_accept   = in_valid && w_in_ready;

  // Register-file write port; flush does not suppress writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (w_wr_fire) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  // Output valid tracking: load on accept, drop on flush or consume, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
    end else if (flush || out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Operand capture only on accept, so held operands never see later writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_alu_op <= 3'd0;
    end else if (w_accept) begin
      r_a      <= w_rs_data;
      r_b      <= w_b_sel;
      r_alu_op <= alu_op_in;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign a         = r_a;
  assign b         = r_b;
  assign alu_op    = r_alu_op;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - directed self-checking bench for operand_fetch_stage
module tb_operand_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_ready_z;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [15:0] imm;
  logic        use_imm;
  logic [2:0]  alu_op_in;
  logic        flush;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        out_valid;
  logic        out_valid_z;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] a_z;
  logic [31:0] b;
  logic [31:0] b_z;
  logic [2:0]  alu_op;
  logic [2:0]  alu_op_z;

  int n_checks;
  int n_fail;

  operand_fetch_stage #(.IMM_SIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .imm(imm), .use_imm(use_imm),
    .alu_op_in(alu_op_in), .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .alu_op(alu_op)
  );

  operand_fetch_stage #(.IMM_SIGNED(1'b0)) dut_z (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_z),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .imm(imm), .use_imm(use_imm),
    .alu_op_in(alu_op_in), .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .out_valid(out_valid_z), .out_ready(out_ready),
    .a(a_z), .b(b_z), .alu_op(alu_op_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic ui,
                       input logic [15:0] im, input logic [2:0] op);
    in_valid  = 1'b1;
    rs_addr   = rs;
    rt_addr   = rt;
    use_imm   = ui;
    imm       = im;
    alu_op_in = op;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    rs_addr   = 5'd0;
    rt_addr   = 5'd0;
    imm       = 16'd0;
    use_imm   = 1'b0;
    alu_op_in = 3'd0;
    flush     = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = 5'd0;
    wr_data   = 32'd0;
    out_ready = 1'b1;

    // Reset state
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_a", a, 32'd0);
    check("rst_b", b, 32'd0);
    check("rst_alu_op", {29'd0, alu_op}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    flush = 1'b1;
    #1;
    check("rst_in_ready_flush", {31'd0, in_ready}, 32'd0);
    flush = 1'b0;
    tick();
    rst_n = 1'b1;

    // Write r5 = 0xFF, then read it through rs
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0000_00FF;
    tick();
    wr_en = 1'b0;
    issue(5'd5, 5'd0, 1'b0, 16'd0, 3'b010);
    #1;
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("r5_out_valid", {31'd0, out_valid}, 32'd1);
    check("r5_a", a, 32'h0000_00FF);
    check("r5_b", b, 32'd0);
    check("r5_alu_op", {29'd0, alu_op}, 32'd2);

    // Consumed with no new accept: valid drops, operands hold
    tick();
    check("drain_out_valid", {31'd0, out_valid}, 32'd0);
    check("drain_a_hold", a, 32'h0000_00FF);

    // Same-cycle write to r7 and read of r7: bypass
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF;
    issue(5'd7, 5'd5, 1'b0, 16'd0, 3'b001);
    tick();
    check("bypass_a", a, 32'hDEAD_BEEF);
    check("bypass_b_rt", b, 32'h0000_00FF);

    // Write to r0 ignored, also no bypass on address 0; r7 now from storage
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_1234;
    issue(5'd0, 5'd7, 1'b0, 16'd0, 3'b011);
    tick();
    wr_en = 1'b0;
    check("r0_bypass_a", a, 32'd0);
    check("r7_stored_b", b, 32'hDEAD_BEEF);
    issue(5'd0, 5'd0, 1'b1, 16'h8000, 3'b101);
    tick();
    check("r0_read_a", a, 32'd0);
    check("imm_signed_b", b, 32'hFFFF_8000);
    check("imm_zero_b", b_z, 32'h0000_8000);

    // Backpressure for 3 cycles; a write to r5 during the hold must not disturb held operands
    out_ready = 1'b0;
    issue(5'd5, 5'd7, 1'b0, 16'd0, 3'b110);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0000_0055;
    #1;
    check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      wr_en = 1'b0;
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_a", a, 32'd0);
      check("hold_b", b, 32'hFFFF_8000);
      check("hold_alu_op", {29'd0, alu_op}, 32'd5);
      check("hold_in_ready_c", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("release_out_valid", {31'd0, out_valid}, 32'd1);
    check("release_a", a, 32'h0000_0055);
    check("release_b", b, 32'hDEAD_BEEF);
    check("release_alu_op", {29'd0, alu_op}, 32'd6);

    // Flush with a valid output and a valid input; the write in the flush cycle still lands
    out_ready = 1'b0;
    flush = 1'b1;
    issue(5'd5, 5'd0, 1'b1, 16'h0077, 3'b111);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0033;
    #1;
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0; wr_en = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_a_hold", a, 32'h0000_0055);
    check("flush_alu_op_hold", {29'd0, alu_op}, 32'd6);
    tick();
    check("flush_no_ghost", {31'd0, out_valid}, 32'd0);
    check("flush_b_hold", b, 32'hDEAD_BEEF);
    out_ready = 1'b1;
    issue(5'd3, 5'd0, 1'b0, 16'd0, 3'b011);
    tick();
    check("flush_write_r3", a, 32'h0000_0033);

    // Back-to-back: consume and accept on the same edge
    issue(5'd3, 5'd0, 1'b1, 16'h0001, 3'b100);
    tick();
    check("b2b1_out_valid", {31'd0, out_valid}, 32'd1);
    check("b2b1_b", b, 32'h0000_0001);
    check("b2b1_alu_op", {29'd0, alu_op}, 32'd4);
    issue(5'd5, 5'd0, 1'b1, 16'h7FFF, 3'b010);
    tick();
    check("b2b2_out_valid", {31'd0, out_valid}, 32'd1);
    check("b2b2_a", a, 32'h0000_0055);
    check("b2b2_b_signed", b, 32'h0000_7FFF);
    check("b2b2_b_zero", b_z, 32'h0000_7FFF);

    // Asynchronous reset mid-stream
    issue(5'd3, 5'd0, 1'b0, 16'd0, 3'b001);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_out_valid", {31'd0, out_valid}, 32'd0);
    check("areset_a", a, 32'd0);
    check("areset_b", b, 32'd0);
    check("areset_alu_op", {29'd0, alu_op}, 32'd0);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_reset_empty", {31'd0, out_valid}, 32'd0);
    issue(5'd3, 5'd5, 1'b0, 16'd0, 3'b001);
    tick();
    in_valid = 1'b0;
    check("post_reset_valid", {31'd0, out_valid}, 32'd1);
    check("post_reset_r3", a, 32'd0);
    check("post_reset_r5", b, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
